// File: rtl/fpu_dispatch.sv
// fpu_dispatch
// Queues floating-point requests in a small FIFO, issues them one at a time
// to an external arithmetic unit, and holds each result in a single response
// slot until downstream accepts it.
//
// Parameters:
//   DEPTH  request FIFO entries (power of two, 2..16)
//   TAG_W  width of the request/response tag
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_a, req_b, req_op     request operands and operation code
//   req_tag                  request identifier, returned with the result
//   fpu_a, fpu_b, fpu_op     registered operands to the arithmetic unit
//   fpu_result, fpu_valid    result and result-valid from the arithmetic unit
//   rsp_valid/rsp_ready      response handshake
//   rsp_result, rsp_tag      captured result and its tag
//   rsp_dz                   divide-by-zero flag (FPU_DISPATCH_DZ_EN only)
//   busy                     work queued, in flight, or awaiting pickup
//
// Configuration:
//   FPU_DISPATCH_DZ_EN  when defined, adds the rsp_dz output.

module fpu_dispatch #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [2:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  output logic [2:0]       fpu_op,
  input  logic [31:0]      fpu_result,
  input  logic             fpu_valid,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
`ifdef FPU_DISPATCH_DZ_EN
  output logic             rsp_dz,
`endif
  output logic             busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE
  } state_t;

  state_t state, next_state;

  logic [31:0]      a_mem   [DEPTH];
  logic [31:0]      b_mem   [DEPTH];
  logic [2:0]       op_mem  [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [TAG_W-1:0] issued_tag;

  logic push, pop, capture;

  // Readiness comes from the registered count only, so a pop in the same
  // cycle does not make a full FIFO look ready.
  assign req_ready = (count != CNT_W'(DEPTH));
  assign push      = req_valid && req_ready;
  assign busy      = (state != IDLE) || (count != '0) || rsp_valid;

  // Storage has no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      a_mem[wr_ptr]   <= req_a;
      b_mem[wr_ptr]   <= req_b;
      op_mem[wr_ptr]  <= req_op;
      tag_mem[wr_ptr] <= req_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Capture needs the response slot empty or being drained on this same edge.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        next_state = CAPTURE;
      end
      CAPTURE: begin
        if (fpu_valid && (!rsp_valid || rsp_ready)) begin
          capture    = 1'b1;
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fpu_a      <= '0;
      fpu_b      <= '0;
      fpu_op     <= '0;
      issued_tag <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_tag    <= '0;
`ifdef FPU_DISPATCH_DZ_EN
      rsp_dz     <= 1'b0;
`endif
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        fpu_a      <= a_mem[rd_ptr];
        fpu_b      <= b_mem[rd_ptr];
        fpu_op     <= op_mem[rd_ptr];
        issued_tag <= tag_mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (capture) begin
        rsp_valid  <= 1'b1;
        rsp_result <= fpu_result;
        rsp_tag    <= issued_tag;
`ifdef FPU_DISPATCH_DZ_EN
        rsp_dz     <= (fpu_op == 3'd3) && (fpu_b == 32'd0);
`endif
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fpu_dispatch.sv
// tb_fpu_dispatch
// Directed bench for fpu_dispatch with a one-cycle integer stand-in for the
// arithmetic unit (add, sub, mul, div with x/0 = 0, reserved codes = a ^ b).

module tb_fpu_dispatch;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [31:0]      req_a = '0;
  logic [31:0]      req_b = '0;
  logic [2:0]       req_op = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [31:0]      fpu_a, fpu_b;
  logic [2:0]       fpu_op;
  logic [31:0]      fpu_result;
  logic             fpu_valid;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
`ifdef FPU_DISPATCH_DZ_EN
  logic             rsp_dz;
`endif
  logic             busy;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  fpu_dispatch #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .req_tag    (req_tag),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_op     (fpu_op),
    .fpu_result (fpu_result),
    .fpu_valid  (fpu_valid),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_tag    (rsp_tag),
`ifdef FPU_DISPATCH_DZ_EN
    .rsp_dz     (rsp_dz),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a * b;
      3'd3:    return (b == 32'd0) ? 32'd0 : a / b;
      default: return a ^ b;
    endcase
  endfunction

  // Arithmetic unit stand-in: result registered one edge after operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpu_result <= '0;
      fpu_valid  <= 1'b0;
    end else begin
      fpu_result <= alu(fpu_a, fpu_b, fpu_op);
      fpu_valid  <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] op, input logic [TAG_W-1:0] tag);
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_tag   = tag;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic waitResponse(input string name, input logic [31:0] exp_res,
                              input logic [TAG_W-1:0] exp_tag, output int at_cycle);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 12 && !seen; n++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    at_cycle = cycle;
    checkOutput({name, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      checkOutput({name, "_result"}, rsp_result, exp_res);
      checkOutput({name, "_tag"}, 32'(rsp_tag), 32'(exp_tag));
    end
  endtask

  logic [31:0]      fill_a   [6] = '{32'd10, 32'd10, 32'd6, 32'd100, 32'd3, 32'hFFFF_FFFF};
  logic [31:0]      fill_b   [6] = '{32'd4, 32'd4, 32'd7, 32'd7, 32'd5, 32'd1};
  logic [2:0]       fill_op  [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd0};
  logic [TAG_W-1:0] fill_tag [6] = '{4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14};
  logic [31:0]      fill_exp [6] = '{32'd14, 32'd6, 32'd42, 32'd14, 32'd6, 32'd0};

  initial begin
    int c_prev, c_now;

    // Reset values
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_fpu_a", fpu_a, 32'd0);
    checkOutput("rst_fpu_op", 32'(fpu_op), 32'd0);
    checkOutput("rst_rsp_result", rsp_result, 32'd0);
    checkOutput("rst_rsp_tag", 32'(rsp_tag), 32'd0);

    // Single op: 5 + 3, tag 2, response on third edge after the push
    rsp_ready = 1'b1;
    applyStimulus(32'd5, 32'd3, 3'd0, 4'd2);
    checkOutput("single_busy", 32'(busy), 32'd1);
    checkOutput("single_e0_valid", 32'(rsp_valid), 32'd0);
    tick();
    checkOutput("single_fpu_a", fpu_a, 32'd5);
    checkOutput("single_fpu_b", fpu_b, 32'd3);
    checkOutput("single_fpu_op", 32'(fpu_op), 32'd0);
    checkOutput("single_e1_valid", 32'(rsp_valid), 32'd0);
    tick();
    checkOutput("single_e2_valid", 32'(rsp_valid), 32'd0);
    tick();
    checkOutput("single_e3_valid", 32'(rsp_valid), 32'd1);
    checkOutput("single_result", rsp_result, 32'd8);
    checkOutput("single_tag", 32'(rsp_tag), 32'd2);
    tick();
    checkOutput("single_consumed", 32'(rsp_valid), 32'd0);
    checkOutput("single_idle_busy", 32'(busy), 32'd0);
    tick();

    // Fill to DEPTH with rsp_ready high; responses in order, 3 cycles apart
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          checkOutput("fill_ready", 32'(req_ready), 32'd1);
          applyStimulus(fill_a[i], fill_b[i], fill_op[i], fill_tag[i]);
        end
        checkOutput("full_ready", 32'(req_ready), 32'd0);
        tick();
        checkOutput("full_ready_hold", 32'(req_ready), 32'd0);
        tick();
        checkOutput("full_ready_reopen", 32'(req_ready), 32'd1);
      end
      begin
        c_prev = 0;
        for (int k = 0; k < 6; k++) begin
          waitResponse("fill", fill_exp[k], fill_tag[k], c_now);
          if (k > 0) checkOutput("fill_spacing", 32'(c_now - c_prev), 32'd3);
          c_prev = c_now;
        end
      end
    join
    tick();
    checkOutput("fill_drained_busy", 32'(busy), 32'd0);

    // Backpressure; the second push lands on the IDLE pop edge with count 1
    rsp_ready = 1'b0;
    applyStimulus(32'd20, 32'd5, 3'd1, 4'd3);
    applyStimulus(32'd7, 32'd6, 3'd2, 4'd4);
    checkOutput("bp_ready_same_cycle", 32'(req_ready), 32'd1);
    tick();
    tick();
    checkOutput("bp_first_valid", 32'(rsp_valid), 32'd1);
    checkOutput("bp_first_result", rsp_result, 32'd15);
    checkOutput("bp_first_tag", 32'(rsp_tag), 32'd3);
`ifdef FPU_DISPATCH_DZ_EN
    checkOutput("bp_first_dz", 32'(rsp_dz), 32'd0);
`endif
    tick();
    tick();
    checkOutput("bp_fpu_a_loaded", fpu_a, 32'd7);
    tick();
    tick();
    tick();
    checkOutput("bp_held_valid", 32'(rsp_valid), 32'd1);
    checkOutput("bp_held_result", rsp_result, 32'd15);
    checkOutput("bp_fpu_a_stable", fpu_a, 32'd7);
    checkOutput("bp_fpu_b_stable", fpu_b, 32'd6);
    checkOutput("bp_fpu_op_stable", 32'(fpu_op), 32'd2);
    checkOutput("bp_busy", 32'(busy), 32'd1);
    rsp_ready = 1'b1;
    tick();
    checkOutput("bp_second_valid", 32'(rsp_valid), 32'd1);
    checkOutput("bp_second_result", rsp_result, 32'd42);
    checkOutput("bp_second_tag", 32'(rsp_tag), 32'd4);
    tick();
    checkOutput("bp_done_valid", 32'(rsp_valid), 32'd0);
    checkOutput("bp_done_busy", 32'(busy), 32'd0);

    // Divide by zero
    req_a     = 32'd9;
    req_b     = 32'd0;
    req_op    = 3'd3;
    req_tag   = 4'd7;
    req_valid = 1'b1;
    fork
      begin
        tick();
        req_valid = 1'b0;
      end
      waitResponse("dz", 32'd0, 4'd7, c_now);
    join
`ifdef FPU_DISPATCH_DZ_EN
    checkOutput("dz_flag", 32'(rsp_dz), 32'd1);
`endif
    tick();
    tick();

    // Reset while in ISSUE with two ops queued
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'(100 + i), 32'd1, 3'd0, 4'(i));
    end
    tick();
    checkOutput("mid_fpu_a", fpu_a, 32'd101);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mid_rst_fpu_a", fpu_a, 32'd0);
    checkOutput("mid_rst_fpu_b", fpu_b, 32'd0);
    checkOutput("mid_rst_fpu_op", 32'(fpu_op), 32'd0);
    checkOutput("mid_rst_rsp_result", rsp_result, 32'd0);
    checkOutput("mid_rst_rsp_tag", 32'(rsp_tag), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_req_ready", 32'(req_ready), 32'd1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
      checkOutput("post_rst_no_issue", fpu_a, 32'd0);
    end
    applyStimulus(32'd1, 32'd2, 3'd0, 4'd5);
    waitResponse("post_rst", 32'd3, 4'd5, c_now);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
